// File: rtl/ysyx_22040210_pkg.sv
// Shared constants for the multi-ported register file: zero word, default geometry and
// the enable/disable levels.
package ysyx_22040210_pkg;

    localparam int unsigned DefXlen = 64;
    localparam int unsigned DefNreg = 32;

    localparam logic [DefXlen-1:0] ZeroWord = '0;

    localparam logic Enable  = 1'b1;
    localparam logic Disable = 1'b0;

endpackage

// File: rtl/ysyx_22040210_rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared on write
// retirement, wiped by flush. Register 0 is never busy.
module ysyx_22040210_rf_scoreboard
    import ysyx_22040210_pkg::*;
#(
    parameter int unsigned NREG = DefNreg,
    parameter int unsigned NWR  = 2,
    localparam int unsigned AW  = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_valid_i,
    input  logic [AW-1:0]     iss_rd_i,
    input  logic              flush_i,
    input  logic [NWR-1:0]    we_i,
    input  logic [NWR*AW-1:0] waddr_i,
    output logic [NREG-1:0]   busy_o
);

    logic [NREG-1:0] busy_q, busy_d;

    // Order matters: clear by writes, then set by issue (issue wins), then flush overrides all.
    always_comb begin
        busy_d = busy_q;
        for (int k = 0; k < NWR; k++) begin
            if (we_i[k] == Enable) begin
                busy_d[waddr_i[k*AW +: AW]] = Disable;
            end
        end
        if (iss_valid_i == Enable) begin
            busy_d[iss_rd_i] = Enable;
        end
        if (flush_i == Enable) begin
            busy_d = '0;
        end
        busy_d[0] = Disable;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/ysyx_22040210_regfile_mp.sv
// Multi-ported register file with write-to-read bypass and highest-port-wins write priority.
// Optional pending-write scoreboard enabled by defining YSYX_22040210_RF_SCOREBOARD_EN.
module ysyx_22040210_regfile_mp
    import ysyx_22040210_pkg::*;
#(
    parameter int unsigned XLEN = DefXlen,
    parameter int unsigned NREG = DefNreg,
    parameter int unsigned NRD  = 4,
    parameter int unsigned NWR  = 2,
    localparam int unsigned AW  = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NWR-1:0]      we_i,
    input  logic [NWR*AW-1:0]   waddr_i,
    input  logic [NWR*XLEN-1:0] wdata_i,
    input  logic [NRD-1:0]      re_i,
    input  logic [NRD*AW-1:0]   raddr_i,
    output logic [NRD*XLEN-1:0] rdata_o,
    output logic [NRD-1:0]      busy_o,
    input  logic                iss_valid_i,
    input  logic [AW-1:0]       iss_rd_i,
    input  logic                flush_i
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [NREG-1:0] busy_vec;
    logic [XLEN-1:0] fwd [NRD];
    logic [NRD-1:0]  hit;

    // Later ports overwrite earlier ones in the loop, giving the highest index priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= XLEN'(ZeroWord);
            end
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (we_i[k] == Enable && waddr_i[k*AW +: AW] != '0) begin
                    regs_q[waddr_i[k*AW +: AW]] <= wdata_i[k*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        busy_o  = '0;
        hit     = '0;
        for (int j = 0; j < NRD; j++) begin
            fwd[j] = regs_q[raddr_i[j*AW +: AW]];
            for (int k = 0; k < NWR; k++) begin
                if (we_i[k] == Enable && waddr_i[k*AW +: AW] == raddr_i[j*AW +: AW]) begin
                    hit[j] = 1'b1;
                    fwd[j] = wdata_i[k*XLEN +: XLEN];
                end
            end
            // Gating on rst keeps a same-cycle bypass from leaking data during reset.
            if (rst && re_i[j] == Enable && raddr_i[j*AW +: AW] != '0) begin
                rdata_o[j*XLEN +: XLEN] = fwd[j];
                busy_o[j]               = busy_vec[raddr_i[j*AW +: AW]] & ~hit[j];
            end
        end
    end

`ifdef YSYX_22040210_RF_SCOREBOARD_EN
    ysyx_22040210_rf_scoreboard #(
        .NREG (NREG),
        .NWR  (NWR)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .iss_valid_i (iss_valid_i),
        .iss_rd_i    (iss_rd_i),
        .flush_i     (flush_i),
        .we_i        (we_i),
        .waddr_i     (waddr_i),
        .busy_o      (busy_vec)
    );
`else
    logic unused_sb;
    assign unused_sb = ^{iss_valid_i, iss_rd_i, flush_i};
    assign busy_vec  = '0;
`endif

endmodule

// File: tb/tb_ysyx_22040210_regfile_mp.sv
// Directed and randomized bench for ysyx_22040210_regfile_mp against an array-based model.
module tb_ysyx_22040210_regfile_mp;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int NRD  = 4;
    localparam int NWR  = 2;
    localparam int AW   = 5;

`ifdef YSYX_22040210_RF_SCOREBOARD_EN
    localparam bit SbEn = 1'b1;
`else
    localparam bit SbEn = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic [NWR-1:0]      we;
    logic [NWR*AW-1:0]   waddr;
    logic [NWR*XLEN-1:0] wdata;
    logic [NRD-1:0]      re;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      busy;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;
    logic                flush;

    logic [XLEN-1:0] m_regs [NREG];
    bit              m_busy [NREG];
    int              checks = 0;
    int              errors = 0;

    always #5 clk = ~clk;

    ysyx_22040210_regfile_mp #(
        .XLEN (XLEN),
        .NREG (NREG),
        .NRD  (NRD),
        .NWR  (NWR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .we_i        (we),
        .waddr_i     (waddr),
        .wdata_i     (wdata),
        .re_i        (re),
        .raddr_i     (raddr),
        .rdata_o     (rdata),
        .busy_o      (busy),
        .iss_valid_i (iss_valid),
        .iss_rd_i    (iss_rd),
        .flush_i     (flush)
    );

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] exp_rdata(int j);
        logic [AW-1:0]   a = raddr[j*AW +: AW];
        logic [XLEN-1:0] v;
        if (!rst || !re[j] || a == 0) return '0;
        v = m_regs[a];
        for (int k = 0; k < NWR; k++)
            if (we[k] && waddr[k*AW +: AW] == a) v = wdata[k*XLEN +: XLEN];
        return v;
    endfunction

    function automatic logic exp_busy(int j);
        logic [AW-1:0] a = raddr[j*AW +: AW];
        if (!SbEn || !rst || !re[j] || a == 0) return 1'b0;
        for (int k = 0; k < NWR; k++)
            if (we[k] && waddr[k*AW +: AW] == a) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        if (!rst) begin
            model_reset();
            return;
        end
        for (int k = 0; k < NWR; k++)
            if (we[k] && waddr[k*AW +: AW] != 0) m_regs[waddr[k*AW +: AW]] = wdata[k*XLEN +: XLEN];
        if (SbEn) begin
            if (flush) begin
                for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
            end else begin
                for (int k = 0; k < NWR; k++)
                    if (we[k]) m_busy[waddr[k*AW +: AW]] = 1'b0;
                if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
            end
        end
    endtask

    task automatic idle();
        we = '0; waddr = '0; wdata = '0; re = '0; raddr = '0;
        iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
    endtask

    task automatic set_wr(input int k, input int a, input logic [XLEN-1:0] d);
        we[k] = 1'b1;
        waddr[k*AW +: AW] = AW'(a);
        wdata[k*XLEN +: XLEN] = d;
    endtask

    task automatic set_rd(input int j, input int a);
        re[j] = 1'b1;
        raddr[j*AW +: AW] = AW'(a);
    endtask

    task automatic check_reads(input string tag);
        #1;
        for (int j = 0; j < NRD; j++) begin
            check($sformatf("%s_rdata%0d", tag, j), rdata[j*XLEN +: XLEN], exp_rdata(j));
            check($sformatf("%s_busy%0d", tag, j), XLEN'(busy[j]), XLEN'(exp_busy(j)));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        model_reset();
        // Reset: all reads zero even with a bypassable write pending.
        for (int j = 0; j < NRD; j++) set_rd(j, j + 1);
        set_wr(0, 1, 64'hDEAD);
        repeat (2) step();
        check_reads("reset");
        check("reset_const", rdata[63:0], 64'h0);
        rst = 1'b1;

        // x5 write then read; x0 stays zero.
        idle(); set_wr(0, 5, 64'h1234); step();
        idle(); set_rd(0, 5); check_reads("x5");
        check("x5_const", rdata[63:0], 64'h1234);
        set_wr(0, 0, 64'hFF); set_rd(1, 0); check_reads("x0_wr"); step();
        idle(); set_rd(0, 0); check_reads("x0_rd");
        check("x0_const", rdata[63:0], 64'h0);

        // Two ports to x7: port 1 wins, both bypass and storage.
        idle(); set_wr(0, 7, 64'hAAAA); set_wr(1, 7, 64'hBBBB); set_rd(0, 7);
        check_reads("x7_byp");
        check("x7_byp_const", rdata[63:0], 64'hBBBB);
        step();
        idle(); set_rd(0, 7); check_reads("x7_st");
        check("x7_st_const", rdata[63:0], 64'hBBBB);

        // Bypass x9 to every read port.
        idle(); set_wr(0, 9, 64'h55);
        for (int j = 0; j < NRD; j++) set_rd(j, 9);
        check_reads("x9_byp");
        for (int j = 0; j < NRD; j++)
            check($sformatf("x9_const%0d", j), rdata[j*XLEN +: XLEN], 64'h55);
        check("x9_busy_const", XLEN'(busy), '0);
        step();

        // Scoreboard: issue, write+issue, flush; issue x4 too.
        idle(); iss_valid = 1'b1; iss_rd = 5'd3; step();
        idle(); set_rd(0, 3); check_reads("iss3");
        check("iss3_const", XLEN'(busy[0]), XLEN'(SbEn));
        set_wr(0, 3, 64'h33); iss_valid = 1'b1; iss_rd = 5'd3; step();
        idle(); set_rd(0, 3); check_reads("wr_iss3");
        check("wr_iss3_const", XLEN'(busy[0]), XLEN'(SbEn));
        flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd4; step();
        idle(); set_rd(0, 3); set_rd(1, 4); check_reads("flush");
        check("flush_const", XLEN'(busy[1:0]), '0);
        iss_valid = 1'b1; iss_rd = 5'd4; step();
        idle(); set_rd(0, 4); check_reads("iss4");
        check("iss4_const", XLEN'(busy[0]), XLEN'(SbEn));

        // Load x1..x31, mark some busy, then async reset mid-cycle with a write in flight.
        for (int r = 1; r < NREG; r += 2) begin
            idle();
            set_wr(0, r, 64'h1000 + 64'(r));
            if (r + 1 < NREG) set_wr(1, r + 1, 64'h1000 + 64'(r + 1));
            iss_valid = 1'b1; iss_rd = AW'(r);
            step();
        end
        for (int g = 0; g < NREG; g += NRD) begin
            idle();
            for (int j = 0; j < NRD; j++) set_rd(j, g + j);
            check_reads($sformatf("load%0d", g));
        end
        idle(); set_wr(0, 6, 64'hBAD); set_rd(0, 6); set_rd(1, 1); set_rd(2, 2); set_rd(3, 31);
        #2 rst = 1'b0;
        check_reads("midrst");
        check("midrst_const", rdata[63:0] | rdata[127:64], 64'h0);
        step();
        rst = 1'b1;
        for (int g = 0; g < NREG; g += NRD) begin
            idle();
            for (int j = 0; j < NRD; j++) set_rd(j, g + j);
            check_reads($sformatf("postrst%0d", g));
        end
        idle(); set_wr(1, 6, 64'h66); step();
        idle(); set_rd(0, 6); check_reads("firstwr");
        check("firstwr_const", rdata[63:0], 64'h66);

        // Randomized traffic; small address space raises collision rate.
        for (int n = 0; n < 400; n++) begin
            we = NWR'($urandom);
            re = NRD'($urandom);
            for (int k = 0; k < NWR; k++) begin
                waddr[k*AW +: AW] = AW'($urandom_range(0, 7));
                wdata[k*XLEN +: XLEN] = {$urandom, $urandom};
            end
            for (int j = 0; j < NRD; j++) raddr[j*AW +: AW] = AW'($urandom_range(0, 7));
            iss_valid = 1'($urandom);
            iss_rd = AW'($urandom_range(0, 7));
            flush = ($urandom_range(0, 15) == 0);
            check_reads($sformatf("rand%0d", n));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
